// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a word-addressed data memory.
// Converts RV32I byte-addressed loads/stores to word accesses; SB/SH use read-modify-write.
module lsu_ctrl #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  input  logic [n-1:0] mem_rdata,
  output logic [n-1:0] mem_addr,
  output logic         mem_we,
  output logic [n-1:0] mem_wdata,
  output logic [n-1:0] load_data,
  output logic         done,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e       state_q, state_d;
  logic [2:0]   f3_q, f3_d;
  logic         we_q, we_d;
  logic [1:0]   off_q, off_d;
  logic [15:0]  wdata_q, wdata_d;
  logic         err_q, err_d;
  logic [n-1:0] mem_addr_q, mem_addr_d;
  logic [n-1:0] mem_wdata_q, mem_wdata_d;
  logic [n-1:0] load_data_q, load_data_d;

  logic         req_err_c;
  logic [7:0]   byte_c;
  logic [15:0]  half_c;
  logic [n-1:0] ext_c;
  logic [n-1:0] merged_c;

  // Illegal width code or misaligned access, decided on the incoming request
  always_comb begin
    req_err_c = 1'b0;
    case (funct3)
      3'b000, 3'b100: req_err_c = 1'b0;
      3'b001, 3'b101: req_err_c = addr[0];
      3'b010:         req_err_c = (addr[1:0] != 2'b00);
      default:        req_err_c = 1'b1;
    endcase
    if (req_we && funct3[2]) req_err_c = 1'b1;
  end

  // Load alignment/extension and store merge on the word read in RD
  always_comb begin
    byte_c   = mem_rdata[{off_q, 3'b000} +: 8];
    half_c   = off_q[1] ? mem_rdata[16 +: 16] : mem_rdata[0 +: 16];
    ext_c    = mem_rdata;
    merged_c = mem_rdata;
    case (f3_q)
      3'b000:  ext_c = {{(n-8){byte_c[7]}}, byte_c};
      3'b001:  ext_c = {{(n-16){half_c[15]}}, half_c};
      3'b100:  ext_c = {{(n-8){1'b0}}, byte_c};
      3'b101:  ext_c = {{(n-16){1'b0}}, half_c};
      default: ext_c = mem_rdata;
    endcase
    if (!f3_q[0]) merged_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else          merged_c[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    we_d        = we_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d       = funct3;
          we_d       = req_we;
          off_d      = addr[1:0];
          wdata_d    = wdata[15:0];
          err_d      = req_err_c;
          mem_addr_d = n'(addr[n-1:2]);
          if (req_err_c) begin
            state_d = DONE;
          end else if (req_we && funct3 == 3'b010) begin
            mem_wdata_d = wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          mem_wdata_d = merged_c;
          state_d     = WR;
        end else begin
          load_data_d = ext_c;
          state_d     = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0000;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  // Write enable is gated by rst so a reset edge never commits a write
  assign mem_we    = (state_q == WR) & ~rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) & err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word memory behind the memory port.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] load_data;
  logic        done;
  logic        err;
  logic        busy;

  logic [31:0] mem [64];
  logic        tb_clr;
  int          wr_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.n(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .load_data(load_data), .done(done), .err(err), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  // Issue one request from IDLE and check latency to done, err and number of writes
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err, input int exp_wr);
    int  lat;
    int  w0;
    bit  seen;
    logic err_at;
    @(negedge clk);
    drive(we, f3, a, wd);
    w0   = wr_cnt;
    @(posedge clk);
    lat    = 0;
    seen   = 1'b0;
    err_at = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (done) begin
        seen   = 1'b1;
        err_at = err;
      end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err_at), 32'(exp_err));
    chk({tag, "_wr"}, 32'(wr_cnt - w0), 32'(exp_wr));
  endtask

  logic [5:0] busy_pat;
  logic [5:0] done_pat;
  int         w_start;

  initial begin
    rst       = 1'b1;
    tb_clr    = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_clr = 1'b0;
    rst    = 1'b0;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_flags", {28'h0, done, err, busy, mem_we}, 32'h0);

    run_req("sw10", 1'b1, 3'b010, 32'h10, 32'h11111111, 2, 1'b0, 1);
    chk("sw10_mem", mem[4], 32'h11111111);

    // Reset asserted while the SW sits in WR: no write may land
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    w_start = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwr_busy", 32'(busy), 32'd1);
    chk("rstwr_we_pre", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr_we_rst", 32'(mem_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr_mem", mem[4], 32'h11111111);
    chk("rstwr_cnt", 32'(wr_cnt - w_start), 32'd0);
    chk("rstwr_flags", {30'h0, busy, done}, 32'h0);
    chk("rstwr_wdata", mem_wdata, 32'h0);

    run_req("sw20", 1'b1, 3'b010, 32'h20, 32'h12345678, 2, 1'b0, 1);
    run_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 2, 1'b0, 0);
    chk("lw20_data", load_data, 32'h12345678);

    run_req("sb21", 1'b1, 3'b000, 32'h21, 32'h000000AA, 3, 1'b0, 1);
    chk("sb21_mem", mem[8], 32'h1234AA78);
    run_req("lb21", 1'b0, 3'b000, 32'h21, 32'h0, 2, 1'b0, 0);
    chk("lb21_data", load_data, 32'hFFFFFFAA);
    run_req("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 2, 1'b0, 0);
    chk("lbu21_data", load_data, 32'h000000AA);

    run_req("sw20b", 1'b1, 3'b010, 32'h20, 32'h80007FFF, 2, 1'b0, 1);
    run_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 2, 1'b0, 0);
    chk("lh22_data", load_data, 32'hFFFF8000);
    run_req("lhu20", 1'b0, 3'b101, 32'h20, 32'h0, 2, 1'b0, 0);
    chk("lhu20_data", load_data, 32'h00007FFF);
    run_req("sh22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 3, 1'b0, 1);
    chk("sh22_mem", mem[8], 32'hBEEF7FFF);
    run_req("lw20c", 1'b0, 3'b010, 32'h20, 32'h0, 2, 1'b0, 0);
    chk("lw20c_data", load_data, 32'hBEEF7FFF);

    run_req("e_lw21", 1'b0, 3'b010, 32'h21, 32'h0, 1, 1'b1, 0);
    run_req("e_sh23", 1'b1, 3'b001, 32'h23, 32'h1234, 1, 1'b1, 0);
    run_req("e_f011", 1'b0, 3'b011, 32'h20, 32'h0, 1, 1'b1, 0);
    run_req("e_sbu", 1'b1, 3'b100, 32'h20, 32'h55, 1, 1'b1, 0);
    chk("err_load_data", load_data, 32'hBEEF7FFF);
    chk("err_mem", mem[8], 32'hBEEF7FFF);

    // req_valid held for 6 cycles, alternating LW (even) / SW (odd)
    @(negedge clk);
    w_start = wr_cnt;
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      busy_pat[k] = busy;
      done_pat[k] = done;
      if (k == 5) req_valid = 1'b0;
      else if ((k % 2) == 0) drive(1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
      else drive(1'b0, 3'b010, 32'h10, 32'h0);
    end
    repeat (2) @(negedge clk);
    chk("burst_busy", 32'(busy_pat), 32'h1B);
    chk("burst_done", 32'(done_pat), 32'h12);
    chk("burst_wr", 32'(wr_cnt - w_start), 32'd1);
    chk("burst_mem", mem[12], 32'hCAFEF00D);
    chk("burst_ld", load_data, 32'h11111111);
    chk("burst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
